// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN evaluation-window controller.
// Holds the FSM encoding, the steering decision codes and counter widths.
package snn_ctrl_pkg;

    localparam int SENS_W = 12;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_SENS,
        ST_RUN,
        ST_FLUSH,
        ST_REPORT
    } state_t;

    typedef enum logic [1:0] {
        DEC_NONE  = 2'b00,
        DEC_LEFT  = 2'b01,
        DEC_RIGHT = 2'b10,
        DEC_TIE   = 2'b11
    } dec_t;

    function automatic dec_t decide(input logic [CNT_W-1:0] l,
                                    input logic [CNT_W-1:0] r);
        if (l > r)
            return DEC_LEFT;
        else if (r > l)
            return DEC_RIGHT;
        else if (l != '0)
            return DEC_TIE;
        else
            return DEC_NONE;
    endfunction

endpackage

// File: rtl/snn_spike_cnt.sv
// Saturating spike counter with synchronous clear.
// Exposes its next value so the decision can be formed on the final edge.
module snn_spike_cnt
    import snn_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/snn_window_ctrl.sv
// Sequences one SNN evaluation window: clear, sensor latch, run, flush,
// then reports qualified left/right spike counts and a steering decision.
module snn_window_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int WINDOW     = 16,
    parameter int CLR_CYCLES = 2,
    parameter int PIPE_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              sens_valid,
    input  logic [SENS_W-1:0] sens_fl_i,
    input  logic [SENS_W-1:0] sens_ml_i,
    input  logic [SENS_W-1:0] sens_mr_i,
    input  logic [SENS_W-1:0] sens_fr_i,
    input  logic [1:0]        out_spike,
    output logic              snn_en,
    output logic              snn_clr,
    output logic [SENS_W-1:0] sens_fl_o,
    output logic [SENS_W-1:0] sens_ml_o,
    output logic [SENS_W-1:0] sens_mr_o,
    output logic [SENS_W-1:0] sens_fr_o,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cnt_l,
    output logic [CNT_W-1:0]  cnt_r,
    output logic [1:0]        decision
);

    localparam logic [7:0] RUN_LAST   = 8'(WINDOW - 1);
    localparam logic [3:0] CLR_LAST   = 4'(CLR_CYCLES - 1);
    localparam logic [2:0] FLUSH_LAST = 3'(PIPE_LAT - 1);

    state_t            state_q;
    logic [7:0]        run_q;
    logic [3:0]        clr_cnt_q;
    logic [2:0]        flush_q;
    logic              en_q;
    logic              clr_q;
    logic              done_q;
    dec_t              dec_q;
    logic [SENS_W-1:0] fl_q;
    logic [SENS_W-1:0] ml_q;
    logic [SENS_W-1:0] mr_q;
    logic [SENS_W-1:0] fr_q;
    logic [PIPE_LAT-1:0] dly_q;
    logic [PIPE_LAT-1:0] dly_d;

    logic             en_dly;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_l_d;
    logic [CNT_W-1:0] cnt_r_d;

    if (PIPE_LAT == 1) begin : g_dly1
        assign dly_d = en_q;
    end else begin : g_dlyn
        assign dly_d = {dly_q[PIPE_LAT-2:0], en_q};
    end

    // Spikes only count once the enable has crossed the network pipeline.
    assign en_dly  = dly_q[PIPE_LAT-1];
    assign cnt_clr = (state_q == ST_IDLE) && start;

    snn_spike_cnt u_cnt_l (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (en_dly & out_spike[0]),
        .cnt_o   (cnt_l),
        .cnt_d_o (cnt_l_d)
    );

    snn_spike_cnt u_cnt_r (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (en_dly & out_spike[1]),
        .cnt_o   (cnt_r),
        .cnt_d_o (cnt_r_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            run_q     <= '0;
            clr_cnt_q <= '0;
            flush_q   <= '0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
            dec_q     <= DEC_NONE;
            fl_q      <= '0;
            ml_q      <= '0;
            mr_q      <= '0;
            fr_q      <= '0;
            dly_q     <= '0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            dly_q   <= '0;
        end else begin
            dly_q  <= dly_d;
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_CLEAR;
                        clr_q     <= 1'b1;
                        clr_cnt_q <= '0;
                        dec_q     <= DEC_NONE;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= ST_WAIT_SENS;
                        clr_q   <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_SENS: begin
                    if (sens_valid) begin
                        fl_q    <= sens_fl_i;
                        ml_q    <= sens_ml_i;
                        mr_q    <= sens_mr_i;
                        fr_q    <= sens_fr_i;
                        en_q    <= 1'b1;
                        run_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (run_q == RUN_LAST) begin
                        en_q    <= 1'b0;
                        flush_q <= '0;
                        state_q <= ST_FLUSH;
                    end else begin
                        run_q <= run_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        state_q <= ST_REPORT;
                        done_q  <= 1'b1;
                        dec_q   <= decide(cnt_l_d, cnt_r_d);
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                ST_REPORT: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign snn_en    = en_q;
    assign snn_clr   = clr_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign decision  = dec_q;
    assign sens_fl_o = fl_q;
    assign sens_ml_o = ml_q;
    assign sens_mr_o = mr_q;
    assign sens_fr_o = fr_q;

endmodule

// File: tb/tb_snn_window_ctrl.sv
// Directed bench for snn_window_ctrl: default-parameter and WINDOW=255
// instances plus a stand-alone saturating counter.
module tb_snn_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam logic [47:0] SENS1 = 48'hA5C_3F1_0E7_FFF;
    localparam logic [47:0] SENS2 = 48'h123_456_789_ABC;

    logic        start_a = 0, abort_a = 0, sv_a = 0;
    logic [11:0] fl_a = 0, ml_a = 0, mr_a = 0, fr_a = 0;
    logic [1:0]  spike_a = 0;
    logic        en_a, clr_a, busy_a, done_a;
    logic [11:0] sfl_a, sml_a, smr_a, sfr_a;
    logic [7:0]  cl_a, cr_a;
    logic [1:0]  dec_a;

    logic        start_b = 0, abort_b = 0, sv_b = 0;
    logic [11:0] fl_b = 0, ml_b = 0, mr_b = 0, fr_b = 0;
    logic [1:0]  spike_b = 0;
    logic        en_b, clr_b, busy_b, done_b;
    logic [11:0] sfl_b, sml_b, smr_b, sfr_b;
    logic [7:0]  cl_b, cr_b;
    logic [1:0]  dec_b;

    logic        pc_clr = 0, pc_inc = 0;
    logic [7:0]  pc_cnt, pc_cnt_d;

    snn_window_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .sens_valid(sv_a),
        .sens_fl_i(fl_a), .sens_ml_i(ml_a),
        .sens_mr_i(mr_a), .sens_fr_i(fr_a),
        .out_spike(spike_a), .snn_en(en_a), .snn_clr(clr_a),
        .sens_fl_o(sfl_a), .sens_ml_o(sml_a),
        .sens_mr_o(smr_a), .sens_fr_o(sfr_a),
        .busy(busy_a), .done(done_a),
        .cnt_l(cl_a), .cnt_r(cr_a), .decision(dec_a)
    );

    snn_window_ctrl #(.WINDOW(255)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .sens_valid(sv_b),
        .sens_fl_i(fl_b), .sens_ml_i(ml_b),
        .sens_mr_i(mr_b), .sens_fr_i(fr_b),
        .out_spike(spike_b), .snn_en(en_b), .snn_clr(clr_b),
        .sens_fl_o(sfl_b), .sens_ml_o(sml_b),
        .sens_mr_o(smr_b), .sens_fr_o(sfr_b),
        .busy(busy_b), .done(done_b),
        .cnt_l(cl_b), .cnt_r(cr_b), .decision(dec_b)
    );

    snn_spike_cnt u_pc (
        .clk(clk), .rst(rst), .clr_i(pc_clr), .inc_i(pc_inc),
        .cnt_o(pc_cnt), .cnt_d_o(pc_cnt_d)
    );

    int total = 0;
    int bad   = 0;

    // Window observations, filled by run_std.
    int          nclr, nen, ndone, last_en, done_c;
    int          abort_at, xs1, xs2, xs3;
    logic [7:0]  dl, dr, cl1, cl12;
    logic [1:0]  ddec, dec1;
    logic        busy12, en12;
    logic [47:0] dsens;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Standard schedule: start at c0, sensors valid from c2 (taken at c3),
    // RUN c4..c19, FLUSH c20..c21, REPORT c22.
    task automatic run_std(input int budget, input int mode);
        nclr = 0; nen = 0; ndone = 0; last_en = -1; done_c = -1;
        for (int c = 0; c < budget; c++) begin
            if (clr_a) nclr++;
            if (en_a) begin nen++; last_en = c; end
            if (done_a) begin
                ndone++; done_c = c; dl = cl_a; dr = cr_a; ddec = dec_a;
                dsens = {sfl_a, sml_a, smr_a, sfr_a};
            end
            if (c == 1) begin cl1 = cl_a; dec1 = dec_a; end
            if (c == 12) begin busy12 = busy_a; en12 = en_a; cl12 = cl_a; end
            start_a = (c == 0) || (c == xs1) || (c == xs2) || (c == xs3);
            abort_a = (c == abort_at);
            sv_a    = (c >= 2);
            {fl_a, ml_a, mr_a, fr_a} = (c <= 3) ? SENS1 : SENS2;
            case (mode)
                0: spike_a = 2'b01;
                1: spike_a = (c <= 3 || (c >= 6 && c <= 10)) ? 2'b11 : 2'b00;
                2: spike_a = 2'b00;
                default: spike_a = 2'b10;
            endcase
            step();
        end
        start_a = 0; abort_a = 0; sv_a = 0; spike_a = 0;
        abort_at = -1; xs1 = -1; xs2 = -1; xs3 = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if ({en_a, clr_a, busy_a, done_a} !== 4'b0) begin
            bad++; $display("FAIL reset_ctl_a: got %b want 0000",
                            {en_a, clr_a, busy_a, done_a}); end
        total++; if ({cl_a, cr_a, dec_a} !== 18'd0) begin
            bad++; $display("FAIL reset_cnt_a: got %h want 0",
                            {cl_a, cr_a, dec_a}); end
        total++; if ({sfl_a, sml_a, smr_a, sfr_a} !== 48'd0) begin
            bad++; $display("FAIL reset_sens_a: got %h want 0",
                            {sfl_a, sml_a, smr_a, sfr_a}); end
        total++; if ({en_b, busy_b, done_b, cr_b, dec_b} !== 13'd0) begin
            bad++; $display("FAIL reset_b: got %h want 0",
                            {en_b, busy_b, done_b, cr_b, dec_b}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_std(30, 0);
        total++; if (nclr !== 2) begin
            bad++; $display("FAIL basic_clr_cycles: got %0d want 2", nclr); end
        total++; if (nen !== 16) begin
            bad++; $display("FAIL basic_en_cycles: got %0d want 16", nen); end
        total++; if (ndone !== 1 || done_c !== last_en + 3) begin
            bad++; $display("FAIL basic_done: got n=%0d at %0d want 1 at %0d",
                            ndone, done_c, last_en + 3); end
        total++; if ({dl, dr, ddec} !== {8'd16, 8'd0, 2'b01}) begin
            bad++; $display("FAIL basic_result: got l=%0d r=%0d d=%b want 16 0 01",
                            dl, dr, ddec); end
        total++; if (dsens !== SENS1) begin
            bad++; $display("FAIL basic_sens: got %h want %h", dsens, SENS1); end
        total++; if ({busy_a, cl_a, dec_a} !== {1'b0, 8'd16, 2'b01}) begin
            bad++; $display("FAIL basic_hold: got b=%b l=%0d d=%b want 0 16 01",
                            busy_a, cl_a, dec_a); end
    endtask

    task automatic test_tie();
        run_std(30, 1);
        total++; if ({cl1, dec1} !== 10'd0) begin
            bad++; $display("FAIL tie_clear_entry: got l=%0d d=%b want 0 00",
                            cl1, dec1); end
        total++; if ({dl, dr, ddec} !== {8'd5, 8'd5, 2'b11}) begin
            bad++; $display("FAIL tie_result: got l=%0d r=%0d d=%b want 5 5 11",
                            dl, dr, ddec); end
    endtask

    task automatic test_no_spike();
        run_std(30, 2);
        total++; if (ndone !== 1) begin
            bad++; $display("FAIL none_done: got %0d want 1", ndone); end
        total++; if ({dl, dr, ddec} !== 18'd0) begin
            bad++; $display("FAIL none_result: got l=%0d r=%0d d=%b want 0 0 00",
                            dl, dr, ddec); end
    endtask

    task automatic test_abort();
        abort_at = 11;
        run_std(30, 0);
        total++; if ({busy12, en12} !== 2'b00) begin
            bad++; $display("FAIL abort_idle: got busy=%b en=%b want 0 0",
                            busy12, en12); end
        total++; if (nen !== 8 || ndone !== 0) begin
            bad++; $display("FAIL abort_en_done: got en=%0d done=%0d want 8 0",
                            nen, ndone); end
        total++; if (cl12 !== 8'd6 || cl_a !== 8'd6) begin
            bad++; $display("FAIL abort_partial: got %0d/%0d want 6",
                            cl12, cl_a); end
        run_std(30, 3);
        total++; if (cl1 !== 8'd0) begin
            bad++; $display("FAIL abort_restart_zero: got %0d want 0", cl1); end
        total++; if ({dl, dr, ddec, nen[7:0]} !== {8'd0, 8'd16, 2'b10, 8'd16}) begin
            bad++; $display("FAIL abort_restart: got l=%0d r=%0d d=%b en=%0d want 0 16 10 16",
                            dl, dr, ddec, nen); end
    endtask

    task automatic test_busy_start();
        xs1 = 5; xs2 = 12; xs3 = 20;
        run_std(40, 0);
        total++; if (ndone !== 1 || nclr !== 2 || nen !== 16) begin
            bad++; $display("FAIL busy_start: got done=%0d clr=%0d en=%0d want 1 2 16",
                            ndone, nclr, nen); end
        total++; if (busy_a !== 1'b0 || dl !== 8'd16) begin
            bad++; $display("FAIL busy_start_end: got busy=%b l=%0d want 0 16",
                            busy_a, dl); end
    endtask

    task automatic test_reset_flush();
        int nd;
        run_std(21, 0);
        total++; if ({busy_a, en_a, cl_a} !== {1'b1, 1'b0, 8'd15}) begin
            bad++; $display("FAIL flush_pre: got busy=%b en=%b l=%0d want 1 0 15",
                            busy_a, en_a, cl_a); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({en_a, clr_a, busy_a, done_a, cl_a, cr_a, dec_a} !== 22'd0) begin
            bad++; $display("FAIL async_rst: got %h want 0",
                            {en_a, clr_a, busy_a, done_a, cl_a, cr_a, dec_a}); end
        total++; if ({sfl_a, sml_a, smr_a, sfr_a} !== 48'd0) begin
            bad++; $display("FAIL async_rst_sens: got %h want 0",
                            {sfl_a, sml_a, smr_a, sfr_a}); end
        #1;
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done_a || busy_a) nd++;
        end
        total++; if (nd !== 0) begin
            bad++; $display("FAIL rst_discard: got %0d busy/done cycles want 0", nd); end
    endtask

    task automatic test_window255();
        int  ne, nd, le, dc;
        logic wrapped;
        logic [7:0] prev, r_at, l_at;
        logic [1:0] d_at;
        ne = 0; nd = 0; le = -1; dc = -1; wrapped = 0; prev = 0;
        r_at = 0; l_at = 0; d_at = 0;
        spike_b = 2'b10;
        for (int c = 0; c < 280; c++) begin
            if (en_b) begin ne++; le = c; end
            if (cr_b < prev) wrapped = 1;
            prev = cr_b;
            if (done_b) begin nd++; dc = c; r_at = cr_b; l_at = cl_b; d_at = dec_b; end
            start_b = (c == 0);
            sv_b = (c >= 2);
            step();
        end
        spike_b = 0; sv_b = 0;
        total++; if (ne !== 255 || nd !== 1 || dc !== le + 3) begin
            bad++; $display("FAIL w255_timing: got en=%0d done=%0d@%0d want 255 1@%0d",
                            ne, nd, dc, le + 3); end
        total++; if ({l_at, r_at, d_at} !== {8'd0, 8'd255, 2'b10}) begin
            bad++; $display("FAIL w255_result: got l=%0d r=%0d d=%b want 0 255 10",
                            l_at, r_at, d_at); end
        total++; if (wrapped !== 1'b0) begin
            bad++; $display("FAIL w255_wrap: got wrap=%b want 0", wrapped); end
    endtask

    task automatic test_preload();
        pc_clr = 1'b1;
        step();
        pc_clr = 1'b0;
        pc_inc = 1'b1;
        repeat (254) step();
        total++; if (pc_cnt !== 8'd254) begin
            bad++; $display("FAIL preload_254: got %0d want 254", pc_cnt); end
        step();
        total++; if (pc_cnt !== 8'd255) begin
            bad++; $display("FAIL preload_255: got %0d want 255", pc_cnt); end
        total++; if (pc_cnt_d !== 8'd255) begin
            bad++; $display("FAIL sat_next: got %0d want 255", pc_cnt_d); end
        step();
        total++; if (pc_cnt !== 8'd255) begin
            bad++; $display("FAIL sat_hold: got %0d want 255", pc_cnt); end
        pc_inc = 1'b0;
    endtask

    initial begin
        abort_at = -1; xs1 = -1; xs2 = -1; xs3 = -1;
        test_reset();
        test_basic();
        test_tie();
        test_no_spike();
        test_abort();
        test_busy_start();
        test_reset_flush();
        test_window255();
        test_preload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
